// File: rtl/c_rob_if.sv
// c_rob_pkg + c_rob_if: the retire record type and the rename / writeback / retire
// bundle of the two-wide reorder buffer.
// Optional feature macro: ROB_RETIRE_PC_EN (adds the pc field to retire_pkg_t).
package c_rob_pkg;
  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 w_valid;
    logic                 w_check;
    logic [4:0]           arf_id;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          data;
`ifdef ROB_RETIRE_PC_EN
    logic [31:0]          pc;
`endif
  } retire_pkg_t;
endpackage

interface c_rob_if;
  import c_rob_pkg::*;

  logic [1:0]                alloc_valid_i;
  logic [1:0][4:0]           alloc_areg_i;
  logic [1:0]                alloc_wreg_i;
  logic [1:0]                alloc_check_i;
  logic [1:0][31:0]          alloc_pc_i;
  logic [1:0]                wb_valid_i;
  logic [1:0][ROB_WIDTH-1:0] wb_robid_i;
  logic [1:0][31:0]          wb_data_i;
  logic [1:0]                wb_flush_i;
  logic [1:0]                c_retire_o;
  retire_pkg_t [1:0]         c_retire_info_o;
  logic                      c_flush_o;
  logic [ROB_WIDTH:0]        count_o;
  logic                      full_o;
  logic                      overflow_o;

  modport master (
    output alloc_valid_i, alloc_areg_i, alloc_wreg_i, alloc_check_i, alloc_pc_i,
    output wb_valid_i, wb_robid_i, wb_data_i, wb_flush_i,
    input  c_retire_o, c_retire_info_o, c_flush_o, count_o, full_o, overflow_o
  );

  modport slave (
    input  alloc_valid_i, alloc_areg_i, alloc_wreg_i, alloc_check_i, alloc_pc_i,
    input  wb_valid_i, wb_robid_i, wb_data_i, wb_flush_i,
    output c_retire_o, c_retire_info_o, c_flush_o, count_o, full_o, overflow_o
  );
endinterface

// File: rtl/c_rob.sv
// c_rob: two-wide reorder buffer. Compacted in-order allocation at tail, out-of-order
// writeback, in-order registered retire of up to two entries per cycle, and a one-cycle
// pipeline flush when a retiring entry carries a flush mark.
// Optional feature macro: ROB_RETIRE_PC_EN (store the PC per entry and report it on retire).
module c_rob
  import c_rob_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk,
  input  logic   rst,
  c_rob_if.slave rob
);
  localparam int RW = $clog2(DEPTH);
  localparam int CW = RW + 1;

  // Pointer / flag state
  logic [RW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  occ_q, occ_d, cmp_q, cmp_d, fm_q, fm_d;
  logic [1:0]        ret_q, ret_d;
  retire_pkg_t [1:0] info_q, info_d;
  logic              flush_q, flush_d;
  logic              ovf_q, full_q;

  // Entry payload (no reset needed: only read once the entry is occupied and complete)
  logic [4:0]        areg_q [DEPTH];
  logic              wreg_q [DEPTH];
  logic              chk_q  [DEPTH];
  logic [31:0]       data_q [DEPTH];
`ifdef ROB_RETIRE_PC_EN
  logic [31:0]       pc_q   [DEPTH];
`else
  logic              unused_pc_s;
  assign unused_pc_s = ^rob.alloc_pc_i;
`endif

  // Helpers
  logic [1:0]        n_alloc_s, n_alloc_eff_s, n_ret_s;
  logic              ovf_s, alloc_ok_s;
  logic [1:0]        alloc_we_s, wb_hit_s;
  logic [RW-1:0]     alloc_idx_s [2];
  logic [RW-1:0]     head1_s;

  function automatic retire_pkg_t pack_entry(input logic [RW-1:0] idx);
    retire_pkg_t e;
    e         = '0;
    e.w_valid = wreg_q[idx];
    e.w_check = chk_q[idx];
    e.arf_id  = areg_q[idx];
    e.rob_id  = ROB_WIDTH'(idx);
    e.data    = data_q[idx];
`ifdef ROB_RETIRE_PC_EN
    e.pc      = pc_q[idx];
`endif
    return e;
  endfunction

  // Allocation placement, retire decision and next state of pointers and entry flags.
  always_comb begin
    n_alloc_s      = {1'b0, rob.alloc_valid_i[0]} + {1'b0, rob.alloc_valid_i[1]};
    ovf_s          = !flush_q && (rob.alloc_valid_i != 2'b00) &&
                     ((int'(count_q) + int'(n_alloc_s)) > DEPTH);
    alloc_ok_s     = !flush_q && !ovf_s;
    alloc_we_s     = alloc_ok_s ? rob.alloc_valid_i : 2'b00;
    n_alloc_eff_s  = alloc_ok_s ? n_alloc_s : 2'b00;
    alloc_idx_s[0] = tail_q;
    alloc_idx_s[1] = tail_q + RW'(rob.alloc_valid_i[0]);

    // Slot 1 may only retire behind a slot-0 retire that does not redirect.
    head1_s    = head_q + RW'(1'b1);
    ret_d[0]   = !flush_q && occ_q[head_q] && cmp_q[head_q];
    ret_d[1]   = ret_d[0] && !fm_q[head_q] && occ_q[head1_s] && cmp_q[head1_s];
    n_ret_s    = {1'b0, ret_d[0]} + {1'b0, ret_d[1]};
    flush_d    = (ret_d[0] && fm_q[head_q]) || (ret_d[1] && fm_q[head1_s]);
    info_d[0]  = ret_d[0] ? pack_entry(head_q)  : retire_pkg_t'('0);
    info_d[1]  = ret_d[1] ? pack_entry(head1_s) : retire_pkg_t'('0);

    occ_d = occ_q;
    cmp_d = cmp_q;
    fm_d  = fm_q;
    // Writeback only lands on entries occupied before this edge.
    for (int k = 0; k < 2; k++) begin
      wb_hit_s[k] = !flush_q && rob.wb_valid_i[k] && occ_q[rob.wb_robid_i[k]];
      cmp_d[rob.wb_robid_i[k]] = cmp_d[rob.wb_robid_i[k]] | wb_hit_s[k];
      fm_d[rob.wb_robid_i[k]]  = wb_hit_s[k] ? rob.wb_flush_i[k] : fm_d[rob.wb_robid_i[k]];
    end
    occ_d[head_q]  = occ_d[head_q]  & ~ret_d[0];
    occ_d[head1_s] = occ_d[head1_s] & ~ret_d[1];
    // Allocation is applied last so it wins over a same-index writeback.
    for (int k = 0; k < 2; k++) begin
      occ_d[alloc_idx_s[k]] = occ_d[alloc_idx_s[k]] |  alloc_we_s[k];
      cmp_d[alloc_idx_s[k]] = cmp_d[alloc_idx_s[k]] & ~alloc_we_s[k];
      fm_d[alloc_idx_s[k]]  = fm_d[alloc_idx_s[k]]  & ~alloc_we_s[k];
    end

    if (flush_q) begin
      occ_d   = '0;
      cmp_d   = '0;
      fm_d    = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + RW'(n_ret_s);
      tail_d  = tail_q + RW'(n_alloc_eff_s);
      count_d = count_q + CW'(n_alloc_eff_s) - CW'(n_ret_s);
    end
  end

  // Entry payload capture: writeback result first, allocation overrides the same index.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wb_hit_s[k]) begin
        data_q[rob.wb_robid_i[k]] <= rob.wb_data_i[k];
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (alloc_we_s[k]) begin
        areg_q[alloc_idx_s[k]] <= rob.alloc_areg_i[k];
        wreg_q[alloc_idx_s[k]] <= rob.alloc_wreg_i[k];
        chk_q[alloc_idx_s[k]]  <= rob.alloc_check_i[k];
        data_q[alloc_idx_s[k]] <= 32'h0000_0000;
`ifdef ROB_RETIRE_PC_EN
        pc_q[alloc_idx_s[k]]   <= rob.alloc_pc_i[k];
`endif
      end
    end
  end

  // Control state and registered retire outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      cmp_q   <= '0;
      fm_q    <= '0;
      ret_q   <= '0;
      info_q  <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      cmp_q   <= cmp_d;
      fm_q    <= fm_d;
      ret_q   <= ret_d;
      info_q  <= info_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_q | ovf_s;
      full_q  <= int'(count_d) > (DEPTH - 32'sd4);
    end
  end

  assign rob.c_retire_o      = ret_q;
  assign rob.c_retire_info_o = info_q;
  assign rob.c_flush_o       = flush_q;
  assign rob.count_o         = count_q;
  assign rob.full_o          = full_q;
  assign rob.overflow_o      = ovf_q;
endmodule

// File: tb/tb_c_rob.sv
// tb_c_rob: directed bench for c_rob with a queue-based reference model checked every cycle.
module tb_c_rob;
  import c_rob_pkg::*;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] pc_base = 32'h0000_1000;

  c_rob_if rob();
  c_rob #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .rob(rob));

  always #5 clk = ~clk;

  // Reference model: the ROB as an ordered queue of in-flight instructions.
  typedef struct {
    logic [5:0]  id;
    logic [4:0]  areg;
    logic        wreg;
    logic        chk;
    logic        done;
    logic        fl;
    logic [31:0] data;
    logic [31:0] pc;
  } ment_t;

  ment_t             mq[$];
  int                m_tail  = 0;
  logic [1:0]        e_ret   = 2'b00;
  retire_pkg_t [1:0] e_info  = '0;
  logic              e_flush = 1'b0;
  logic              e_ovf   = 1'b0;
  int                e_count = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic retire_pkg_t mk_info(input ment_t e);
    retire_pkg_t r;
    r         = '0;
    r.w_valid = e.wreg;
    r.w_check = e.chk;
    r.arf_id  = e.areg;
    r.rob_id  = e.id;
    r.data    = e.data;
`ifdef ROB_RETIRE_PC_EN
    r.pc      = e.pc;
`endif
    return r;
  endfunction

  task automatic model_step();
    logic r0, r1, ovf;
    int   n;
    ment_t ne;
    if (rst || e_flush) begin
      mq.delete();
      m_tail  = 0;
      e_ret   = 2'b00;
      e_info  = '0;
      e_flush = 1'b0;
      if (rst) e_ovf = 1'b0;
    end else begin
      r0 = (mq.size() > 0) && mq[0].done;
      r1 = r0 && !mq[0].fl && (mq.size() > 1) && mq[1].done;
      e_ret  = {r1, r0};
      e_info = '0;
      if (r0) e_info[0] = mk_info(mq[0]);
      if (r1) e_info[1] = mk_info(mq[1]);
      e_flush = (r0 && mq[0].fl) || (r1 && mq[1].fl);
      for (int k = 0; k < 2; k++)
        if (rob.wb_valid_i[k])
          foreach (mq[j])
            if (mq[j].id == rob.wb_robid_i[k]) begin
              mq[j].done = 1'b1;
              mq[j].data = rob.wb_data_i[k];
              mq[j].fl   = rob.wb_flush_i[k];
            end
      n   = int'(rob.alloc_valid_i[0]) + int'(rob.alloc_valid_i[1]);
      ovf = (n > 0) && (mq.size() + n > DEPTH);
      if (r0) void'(mq.pop_front());
      if (r1) void'(mq.pop_front());
      if (ovf) e_ovf = 1'b1;
      else
        for (int k = 0; k < 2; k++)
          if (rob.alloc_valid_i[k]) begin
            ne.id   = 6'(m_tail);
            ne.areg = rob.alloc_areg_i[k];
            ne.wreg = rob.alloc_wreg_i[k];
            ne.chk  = rob.alloc_check_i[k];
            ne.done = 1'b0;
            ne.fl   = 1'b0;
            ne.data = 32'h0;
            ne.pc   = rob.alloc_pc_i[k];
            mq.push_back(ne);
            m_tail = (m_tail + 1) % DEPTH;
          end
    end
    e_count = mq.size();
  endtask

  // Compare process: advance the model on every edge, check all outputs just after it.
  always begin
    @(posedge clk);
    model_step();
    #1;
    chk("retire",   128'(rob.c_retire_o),      128'(e_ret));
    chk("info",     128'(rob.c_retire_info_o), 128'(e_info));
    chk("flush",    128'(rob.c_flush_o),       128'(e_flush));
    chk("count",    128'(rob.count_o),         128'(e_count));
    chk("full",     128'(rob.full_o),          128'(e_count > DEPTH - 4));
    chk("overflow", 128'(rob.overflow_o),      128'(e_ovf));
  end

  task automatic clr();
    rob.alloc_valid_i = 2'b00; rob.alloc_areg_i = '0; rob.alloc_wreg_i = 2'b00;
    rob.alloc_check_i = 2'b00; rob.alloc_pc_i = '0;
    rob.wb_valid_i = 2'b00; rob.wb_robid_i = '0; rob.wb_data_i = '0; rob.wb_flush_i = 2'b00;
  endtask

  // One cycle of stimulus, applied at a falling edge and held until the next one.
  task automatic step(input logic [1:0] av, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [1:0] wv, input logic [5:0] i0, input logic [31:0] d0,
                      input logic [5:0] i1, input logic [31:0] d1, input logic [1:0] wf);
    rob.alloc_valid_i   = av;
    rob.alloc_areg_i[0] = a0;
    rob.alloc_areg_i[1] = a1;
    rob.alloc_wreg_i    = {a1 != 5'd0, a0 != 5'd0};
    rob.alloc_check_i   = {a1[0], a0[0]};
    rob.alloc_pc_i[0]   = pc_base;
    rob.alloc_pc_i[1]   = pc_base + 32'd4;
    pc_base             = pc_base + 32'd8;
    rob.wb_valid_i      = wv;
    rob.wb_robid_i[0]   = i0;
    rob.wb_robid_i[1]   = i1;
    rob.wb_data_i[0]    = d0;
    rob.wb_data_i[1]    = d1;
    rob.wb_flush_i      = wf;
    @(negedge clk);
    clr();
  endtask

  task automatic idle();
    step(2'b00, 5'd0, 5'd0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
  endtask

  int p0, p1;
  logic [1:0] pv;

  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("lit_rst_count", 128'(rob.count_o), 128'd0);
    chk("lit_rst_ret",   128'(rob.c_retire_o), 128'd0);
    rst = 1'b0;
    idle();
    chk("lit_post_rst_ovf", 128'(rob.overflow_o), 128'd0);

    // Two allocations, out-of-order writeback, dual retire.
    step(2'b11, 5'd3, 5'd5, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_count2", 128'(rob.count_o), 128'd2);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd1, 32'hA, 6'd0, 32'd0, 2'b00);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd0, 32'hB, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_dual_ret",  128'(rob.c_retire_o), 128'd3);
    chk("lit_id0",       128'(rob.c_retire_info_o[0].rob_id), 128'd0);
    chk("lit_data0",     128'(rob.c_retire_info_o[0].data),   128'hB);
    chk("lit_arf0",      128'(rob.c_retire_info_o[0].arf_id), 128'd3);
    chk("lit_id1",       128'(rob.c_retire_info_o[1].rob_id), 128'd1);
    chk("lit_data1",     128'(rob.c_retire_info_o[1].data),   128'hA);
    chk("lit_arf1",      128'(rob.c_retire_info_o[1].arf_id), 128'd5);
    chk("lit_count0",    128'(rob.count_o), 128'd0);

    // Only head complete: single retire, second one later. Slot 1 writes no register.
    step(2'b11, 5'd7, 5'd0, 2'b01, 6'd10, 32'h99, 6'd0, 32'd0, 2'b00);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd2, 32'h22, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_single_ret", 128'(rob.c_retire_o), 128'd1);
    chk("lit_single_id",  128'(rob.c_retire_info_o[0].rob_id), 128'd2);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd3, 32'h33, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_later_ret",  128'(rob.c_retire_o), 128'd1);
    chk("lit_later_id",   128'(rob.c_retire_info_o[0].rob_id), 128'd3);
    chk("lit_later_wv",   128'(rob.c_retire_info_o[0].w_valid), 128'd0);

    // Allocation and writeback to the same index in one cycle: writeback lost.
    step(2'b01, 5'd9, 5'd0, 2'b01, 6'd4, 32'h44, 6'd0, 32'd0, 2'b00);
    idle(); idle();
    chk("lit_alloc_wins", 128'(rob.c_retire_o), 128'd0);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd4, 32'h55, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_wb_after",   128'(rob.c_retire_info_o[0].data), 128'h55);

    // Flush: entry 5 redirects, entry 6 complete behind it; allocations in flush cycle dropped.
    step(2'b11, 5'd1, 5'd2, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    step(2'b00, 5'd0, 5'd0, 2'b11, 6'd5, 32'h5, 6'd6, 32'h6, 2'b01);
    idle();
    chk("lit_flush_ret",   128'(rob.c_retire_o), 128'd1);
    chk("lit_flush",       128'(rob.c_flush_o), 128'd1);
    chk("lit_flush_id",    128'(rob.c_retire_info_o[0].rob_id), 128'd5);
    step(2'b11, 5'd6, 5'd6, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_flush_cnt0",  128'(rob.count_o), 128'd0);
    chk("lit_flush_clr",   128'(rob.c_flush_o), 128'd0);
    step(2'b01, 5'd4, 5'd0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd0, 32'h77, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_restart_id",  128'(rob.c_retire_info_o[0].rob_id), 128'd0);

    // Continuous dual allocate + dual retire across the 63 -> 0 wrap.
    pv = 2'b00; p0 = 0; p1 = 0;
    for (int i = 0; i < 40; i++) begin
      int t0;
      t0 = m_tail;
      step(2'b11, 5'(i % 32), 5'((i + 1) % 32), pv, 6'(p0), 32'(i * 2), 6'(p1), 32'(i * 2 + 1), 2'b00);
      p0 = t0; p1 = (t0 + 1) % DEPTH; pv = 2'b11;
    end
    chk("lit_tail_wrap", 128'(m_tail), 128'd17);
    step(2'b00, 5'd0, 5'd0, pv, 6'(p0), 32'h100, 6'(p1), 32'h101, 2'b00);
    idle(); idle(); idle();
    chk("lit_drain_cnt", 128'(rob.count_o), 128'd0);

    // Fill to the top: full threshold, overflow rejection, count == DEPTH.
    for (int i = 0; i < 30; i++) step(2'b11, 5'd1, 5'd2, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_full60",  128'(rob.full_o), 128'd0);
    step(2'b11, 5'd1, 5'd2, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_full62",  128'(rob.full_o), 128'd1);
    step(2'b01, 5'd1, 5'd0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_cnt63",   128'(rob.count_o), 128'd63);
    chk("lit_noovf",   128'(rob.overflow_o), 128'd0);
    step(2'b11, 5'd1, 5'd2, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_ovf",     128'(rob.overflow_o), 128'd1);
    chk("lit_ovf_cnt", 128'(rob.count_o), 128'd63);
    chk("lit_ovf_tail", 128'(m_tail), 128'd16);
    step(2'b01, 5'd1, 5'd0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_cnt64",   128'(rob.count_o), 128'd64);
    step(2'b01, 5'd1, 5'd0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd17, 32'h17, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_full_ret", 128'(rob.c_retire_info_o[0].rob_id), 128'd17);
    chk("lit_cnt63b",  128'(rob.count_o), 128'd63);

    // Asynchronous reset mid-stream with in-flight entries.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(2'b11, 5'd3, 5'd4, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    chk("lit_cnt10", 128'(rob.count_o), 128'd10);
    step(2'b00, 5'd0, 5'd0, 2'b11, 6'd0, 32'h1, 6'd1, 32'h2, 2'b00);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("lit_async_ret",  128'(rob.c_retire_o), 128'd0);
    chk("lit_async_info", 128'(rob.c_retire_info_o), 128'd0);
    chk("lit_async_cnt",  128'(rob.count_o), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2'b01, 5'd8, 5'd0, 2'b00, 6'd0, 32'd0, 6'd0, 32'd0, 2'b00);
    step(2'b00, 5'd0, 5'd0, 2'b01, 6'd0, 32'h88, 6'd0, 32'd0, 2'b00);
    idle();
    chk("lit_post_async_id", 128'(rob.c_retire_info_o[0].rob_id), 128'd0);
    chk("lit_post_async_rt", 128'(rob.c_retire_o), 128'd1);
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/c_rob.md
C_ROB -- requirements
Module: c_rob

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of ROB entries; `ROB_WIDTH = log2(DEPTH) = 6.
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid_i  in  2  per-slot allocate request from rename.
- alloc_areg_i  in  2x5  destination arch reg.
- alloc_wreg_i  in  2  slot writes a register.
- alloc_check_i  in  2  rename check bit.
- alloc_pc_i  in  2x32  instruction PC.
- wb_valid_i  in  2  writeback strobe.
- wb_robid_i  in  2x6  writeback target entry.
- wb_data_i  in  2x32  result.
- wb_flush_i  in  2  entry must redirect at commit.
- c_retire_o  out  2  retire strobe per slot.
- c_retire_info_o  out  2x retire_pkg_t  {w_valid, w_check, arf_id, rob_id, data}.
- c_flush_o  out  1  pipeline flush.
- count_o  out  7  occupied entries.
- full_o  out  1  count_o > DEPTH-4.
- overflow_o  out  1  sticky illegal-allocate flag.

Function
REQ-003 SHALL hold head and tail pointers (6 bit, wrap modulo DEPTH) and count (7 bit).
REQ-004 Allocation SHALL be compacted: the n = popcount(alloc_valid_i) valid slots are written in slot order at tail, tail+1; tail SHALL advance by n; each entry's complete bit SHALL be cleared.
REQ-005 Allocate with count + n > DEPTH SHALL write nothing, leave tail unchanged, and set overflow_o.
REQ-006 Writeback SHALL set complete, data and the flush mark of entry wb_robid_i, but only if that entry is occupied; writeback to an unoccupied entry SHALL be ignored.
REQ-007 Writeback and allocation to the same index in one cycle: allocation wins.
REQ-008 Slot 0 SHALL retire when head is occupied and complete; slot 1 SHALL retire only when slot 0 retires, slot 0 carries no flush mark, and head+1 is occupied and complete.
REQ-009 Retire outputs SHALL be registered; c_retire_o / c_retire_info_o SHALL appear one cycle after the decision, and head SHALL advance by the retire count in the same edge.
REQ-010 w_valid SHALL equal alloc_wreg of the entry; rob_id SHALL be the entry index.
REQ-011 count next SHALL equal count + allocated - retired, with simultaneous allocate and retire in one cycle supported.
REQ-012 A retiring entry with a flush mark SHALL assert c_flush_o for exactly one cycle, aligned with its c_retire_o.
REQ-013 On the cycle c_flush_o is high:
- all entries invalidated; head = tail = count = 0 next edge.
- allocations and writebacks in that cycle ignored.
- retire strobes next cycle = 0.
REQ-014 Head = tail with count = DEPTH SHALL be treated as full, never empty.

Reset
REQ-015 While rst is high, and at the next edge after release, the following SHALL be 0: head, tail, count, all complete/occupied bits, c_retire_o, c_retire_info_o, c_flush_o, overflow_o, full_o.

Configuration
REQ-016 Macro ROB_RETIRE_PC_EN:
- Defined: each entry stores alloc_pc_i, and retire_pkg_t carries field pc with the retired PC.
- Undefined: no PC storage, alloc_pc_i unused, pc field absent.

Verification
REQ-017 After reset, allocate 2 (areg 3, 5), wb robid 1 then 0 with data 0xA, 0xB -> both retire in one cycle with rob_id 0, 1 and data 0xB, 0xA; count_o returns to 0.
REQ-018 Only slot 0 complete at head -> c_retire_o = 01; slot 1 retires in a later cycle after its writeback.
REQ-019 Entry 0 written back with wb_flush_i and entry 1 complete -> c_retire_o = 01 and c_flush_o = 1 in the same cycle; next cycle count_o = 0, head = tail = 0.
REQ-020 Fill to 64 entries with continuous retire of 2 per cycle -> tail wraps 63 -> 0 with correct rob_id ordering; allocating 2 when count = 63 -> overflow_o = 1 and tail unchanged.
REQ-021 Assert rst mid-stream with 10 occupied entries -> outputs 0 immediately (asynchronous); after release, allocation starts at rob_id 0.
